// File: rtl/rom_rr_read_arbiter.sv
// Round-robin arbiter sharing the two read ports of a combinational ROM among N requesters.
// Up to two grants per cycle (port A, port B); read data lands in per-requester response slots.
module rom_rr_read_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*AW-1:0] req_addr,
  output logic [N-1:0]    gnt,
  output logic [AW-1:0]   rom_addr_a,
  output logic [AW-1:0]   rom_addr_b,
  input  logic [DW-1:0]   rom_data_a,
  input  logic [DW-1:0]   rom_data_b,
  output logic [N-1:0]    rsp_valid,
  output logic [N*DW-1:0] rsp_data,
  output logic            busy
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] ga;
  logic [PW-1:0] gb;
  logic          ga_vld;
  logic          gb_vld;
  logic [PW-1:0] idx;
  logic [N-1:0]  gnt_raw;
  logic [AW-1:0] addr_arr [N];
  logic [DW-1:0] slot     [N];

  for (genvar i = 0; i < int'(N); i++) begin : g_unpack
    assign addr_arr[i]            = req_addr[i*AW +: AW];
    assign rsp_data[i*DW +: DW]   = slot[i];
  end

  // Port A: first requester from ptr; port B: next requester after A, wrapping.
  always_comb begin : arbitrate
    ga      = '0;
    gb      = '0;
    ga_vld  = 1'b0;
    gb_vld  = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!ga_vld && req[idx]) begin
        ga     = idx;
        ga_vld = 1'b1;
      end
    end
    if (ga_vld) begin
      for (int unsigned k = 1; k < N; k++) begin
        idx = PW'((32'(ga) + k) % N);
        if (!gb_vld && req[idx]) begin
          gb     = idx;
          gb_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin : grant_decode
    gnt_raw = '0;
    for (int unsigned i = 0; i < N; i++) begin
      gnt_raw[i] = (ga_vld && (ga == PW'(i))) || (gb_vld && (gb == PW'(i)));
    end
    gnt        = rst_n ? gnt_raw : '0;
    rom_addr_a = ga_vld ? addr_arr[ga] : '0;
    rom_addr_b = gb_vld ? addr_arr[gb] : '0;
  end

  // Pointer advances past the last port that was granted.
  always_comb begin : pointer_next
    ptr_nxt = ptr;
    if (gb_vld) begin
      ptr_nxt = PW'((32'(gb) + 1) % N);
    end else if (ga_vld) begin
      ptr_nxt = PW'((32'(ga) + 1) % N);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      ptr       <= '0;
      rsp_valid <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        slot[i] <= '0;
      end
    end else begin
      ptr       <= ptr_nxt;
      rsp_valid <= gnt_raw;
      busy      <= |gnt_raw;
      if (ga_vld) slot[ga] <= rom_data_a;
      if (gb_vld) slot[gb] <= rom_data_b;
    end
  end

endmodule
